tinyml_cam_multi_line_buffer: RTL
=================================

Name: tinyml_cam_multi_line_buffer

Overview:
Parametrised N-row line buffer for the camera front-end. It accepts a multi-pixel-per-clock raster stream and emits, for each input word, a vertical column of NUM_LINES words at the same horizontal position. The column holds the current row plus the NUM_LINES-1 preceding rows. It sits between the camera capture/debayer stage and the windowed filters and scalers (3x3, 5x5 kernels). It adds a runtime line width, top-border handling, row-validity flags and line-end marking.

Parameters:
P_DEPTH, 10, bits per pixel
PPC, 2, pixels per clock (1, 2 or 4)
PW, P_DEPTH*PPC, bits per stream word
NUM_LINES, 3, rows in output column (2..8); NUM_LINES-1 line memories are instantiated
MAX_FRAME_WIDTH, 640, maximum pixels per line; memory depth per line is MAX_FRAME_WIDTH/PPC words
BORDER_MODE, 0, 0 = zero-fill missing top rows, 1 = replicate oldest available row
WW, $clog2(MAX_FRAME_WIDTH/PPC+1), width of line-width port

Ports:
i_pclk  in  1  pixel clock, rising edge
i_arstn  in  1  asynchronous active-low reset
i_line_width  in  WW  words per line; sampled on vsync falling edge
i_vsync  in  1  frame sync; a 1->0 edge starts a frame
i_valid  in  1  input word qualifier
i_p  in  PW  input word
o_vsync  out  1  i_vsync delayed 2 cycles
o_valid  out  1  i_valid delayed 2 cycles
o_p  out  PW*NUM_LINES  column; [PW-1:0] = current row, slice k = row aged k lines
o_rows_valid  out  NUM_LINES  bit k high when slice k holds real frame data
o_line_end  out  1  high with the last o_valid word of each line

Behaviour:
- Reset (async assert, sync release): all outputs 0; line width register = MAX_FRAME_WIDTH/PPC; word counter 0; write bank 0; line count 0.
- Frame start: on the cycle i_vsync is 0 and was 1 the previous cycle:
  - clear the word counter, write-bank pointer and line count;
  - latch i_line_width; a value of 0 or a value greater than MAX_FRAME_WIDTH/PPC latches MAX_FRAME_WIDTH/PPC;
  - abandon any partial line; its stale memory data is never flagged valid.
- Memory access: each bank is true-dual-port or simple-dual-port RAM with read-first behaviour at address = word counter.
  - On a valid input word, the bank at write pointer w is written with i_p.
  - All banks are read in the same cycle.
- Row mapping: slice k (1..NUM_LINES-1) is read from bank (w-k) mod (NUM_LINES-1). Slice NUM_LINES-1 comes from bank w, captured before the write.
- Latency: exactly 2 cycles from input to o_p, o_valid and o_vsync. Slice 0 is i_p delayed through 2 registers so it aligns with the RAM read data.
- Line end: when a valid word is at word counter = width-1:
  - word counter goes to 0;
  - w advances mod (NUM_LINES-1);
  - line count increments, saturating at NUM_LINES-1;
  - o_line_end is asserted 2 cycles later with that word.
- o_rows_valid:
  - bit 0 is always 1 while o_valid is high;
  - bit k is 1 when the line count at input time is >= k;
  - all bits are 0 when o_valid is low.
- Border handling for a slice with rows_valid bit = 0:
  - BORDER_MODE 0: slice is 0.
  - BORDER_MODE 1: slice equals the highest-index valid slice, which is slice 0 on the first line.
- A vsync edge and a valid word in the same cycle: the frame restart takes priority, and the word is treated as word 0 of line 0.
- Gaps in i_valid, including gaps mid-line, are tolerated. Counters advance only on valid words.
- Extra words beyond the width are impossible because the counter wraps at width. Short lines that end in a vsync edge are discarded.

Test Plan:
- NUM_LINES=3, PPC=2, width 4; 3 lines of words 0x001..0x00C, valid continuous. On the 3rd line, first word 0x009 -> o_p = {0x001,0x005,0x009}, o_rows_valid=3'b111, output 2 cycles after input.
- Same stream, BORDER_MODE 0. Line 0 -> slices 1,2 = 0, rows_valid=3'b001. Line 1, word 0x005 -> {0,0x001,0x005}, rows_valid=3'b011.
- BORDER_MODE 1, same stream. Line 0 word 0x001 -> {0x001,0x001,0x001}. Line 1 word 0x005 -> {0x001,0x001,0x005}.
- i_line_width=0 at vsync edge, MAX_FRAME_WIDTH=16, PPC=2 -> width 8; o_line_end pulses on every 8th valid output word only.
- Random i_valid gaps (about 50% duty) over 5 lines -> column contents identical to the gapless run. o_valid equals i_valid delayed 2.
- Vsync falling edge after 2 words of line 2, then a new frame -> line count restarts, rows_valid=3'b001 on the new first line, no stale data in slices. Async reset mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/tinyml_cam_multi_line_buffer.sv
// tinyml_cam_multi_line_buffer
// N-row line buffer for the camera front-end. For every input word it emits a
// vertical column of NUM_LINES words taken at the same horizontal position:
// the current row plus the NUM_LINES-1 preceding rows. Two pipeline stages:
// stage 1 holds the input word and the RAM read data, and stage 2 builds the
// column with row-validity masking and top-border fill.
module tinyml_cam_multi_line_buffer #(
  parameter int P_DEPTH         = 10,
  parameter int PPC             = 2,
  parameter int PW              = P_DEPTH * PPC,
  parameter int NUM_LINES       = 3,
  parameter int MAX_FRAME_WIDTH = 640,
  parameter int BORDER_MODE     = 0,
  parameter int WW              = $clog2(MAX_FRAME_WIDTH / PPC + 1)
) (
  input  logic                    i_pclk,
  input  logic                    i_arstn,
  input  logic [WW-1:0]           i_line_width,
  input  logic                    i_vsync,
  input  logic                    i_valid,
  input  logic [PW-1:0]           i_p,
  output logic                    o_vsync,
  output logic                    o_valid,
  output logic [PW*NUM_LINES-1:0] o_p,
  output logic [NUM_LINES-1:0]    o_rows_valid,
  output logic                    o_line_end
);

  // Words per line memory, bank count and the widths derived from them.
  localparam int DEPTH = MAX_FRAME_WIDTH / PPC;
  localparam int NB    = NUM_LINES - 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int LW    = $clog2(NUM_LINES);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [WW-1:0] DEPTH_W   = WW'(DEPTH);
  localparam logic [LW-1:0] LC_MAX    = LW'(NB);
  localparam logic [BW-1:0] BANK_LAST = BW'(NB - 1);

  // Frame-level state.
  logic          vs_d1_r;
  logic [WW-1:0] width_r;
  logic [WW-1:0] word_cnt_r;
  logic [BW-1:0] wbank_r;
  logic [LW-1:0] line_cnt_r;

  // Stage-1 pipeline registers.
  logic [PW-1:0] p_d1_r;
  logic          valid_d1_r;
  logic [LW-1:0] lc_d1_r;
  logic [BW-1:0] bank_d1_r;
  logic          end_d1_r;

  // Effective (frame-start aware) view of the state for the word arriving now.
  logic          frame_start_s;
  logic [WW-1:0] width_in_s;
  logic [WW-1:0] eff_width_s;
  logic [WW-1:0] eff_cnt_s;
  logic [BW-1:0] eff_bank_s;
  logic [LW-1:0] eff_lc_s;
  logic          last_word_s;
  logic [WW-1:0] nxt_cnt_s;
  logic [BW-1:0] nxt_bank_s;
  logic [LW-1:0] nxt_lc_s;
  logic [AW-1:0] ram_addr_s;

  // Read data of every bank, one cycle after the address was presented.
  logic [PW-1:0] rd_data_s [NB];

  // Stage-2 column assembly.
  logic [PW-1:0]           col_s [NUM_LINES];
  logic [PW*NUM_LINES-1:0] nxt_p_s;
  logic [NUM_LINES-1:0]    nxt_rows_s;

  // Frame restart wins over the stored counters; a bad width falls back to the maximum.
  always_comb begin
    frame_start_s = vs_d1_r & ~i_vsync;
    if ((i_line_width == {WW{1'b0}}) || (i_line_width > DEPTH_W)) begin
      width_in_s = DEPTH_W;
    end else begin
      width_in_s = i_line_width;
    end
    if (frame_start_s) begin
      eff_width_s = width_in_s;
      eff_cnt_s   = {WW{1'b0}};
      eff_bank_s  = {BW{1'b0}};
      eff_lc_s    = {LW{1'b0}};
    end else begin
      eff_width_s = width_r;
      eff_cnt_s   = word_cnt_r;
      eff_bank_s  = wbank_r;
      eff_lc_s    = line_cnt_r;
    end
    last_word_s = i_valid & (eff_cnt_s == (eff_width_s - WW'(1)));
    ram_addr_s  = eff_cnt_s[AW-1:0];
  end

  // Next-state of the word counter, write bank and saturating line count.
  always_comb begin
    nxt_cnt_s  = eff_cnt_s;
    nxt_bank_s = eff_bank_s;
    nxt_lc_s   = eff_lc_s;
    if (last_word_s) begin
      nxt_cnt_s = {WW{1'b0}};
      if (eff_bank_s == BANK_LAST) begin
        nxt_bank_s = {BW{1'b0}};
      end else begin
        nxt_bank_s = eff_bank_s + BW'(1);
      end
      if (eff_lc_s == LC_MAX) begin
        nxt_lc_s = LC_MAX;
      end else begin
        nxt_lc_s = eff_lc_s + LW'(1);
      end
    end else if (i_valid) begin
      nxt_cnt_s = eff_cnt_s + WW'(1);
    end else begin
      nxt_cnt_s = eff_cnt_s;
    end
  end

  // Frame-level state update; only valid words move the counters.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      vs_d1_r    <= 1'b0;
      width_r    <= DEPTH_W;
      word_cnt_r <= {WW{1'b0}};
      wbank_r    <= {BW{1'b0}};
      line_cnt_r <= {LW{1'b0}};
    end else begin
      vs_d1_r    <= i_vsync;
      width_r    <= eff_width_s;
      word_cnt_r <= nxt_cnt_s;
      wbank_r    <= nxt_bank_s;
      line_cnt_r <= nxt_lc_s;
    end
  end

  // One line memory per bank, read-first so the oldest row is captured before it is overwritten.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [PW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_q;
    logic          we_s;

    assign we_s         = i_valid && (eff_bank_s == BW'(b));
    assign rd_data_s[b] = rd_q;

    // Read-first RAM port shared by the write and the column read.
    always_ff @(posedge i_pclk) begin
      if (we_s) begin
        mem[ram_addr_s] <= i_p;
      end
      rd_q <= mem[ram_addr_s];
    end
  end

  // Stage 1: delay the live word and its context to line up with the RAM read data.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      p_d1_r     <= {PW{1'b0}};
      valid_d1_r <= 1'b0;
      lc_d1_r    <= {LW{1'b0}};
      bank_d1_r  <= {BW{1'b0}};
      end_d1_r   <= 1'b0;
    end else begin
      p_d1_r     <= i_p;
      valid_d1_r <= i_valid;
      lc_d1_r    <= eff_lc_s;
      bank_d1_r  <= eff_bank_s;
      end_d1_r   <= last_word_s;
    end
  end

  // Map banks to row ages: slice k is the bank k positions behind the write bank.
  always_comb begin
    int bi;
    bi       = 0;
    col_s[0] = p_d1_r;
    for (int k = 1; k < NUM_LINES; k++) begin
      bi       = (int'(bank_d1_r) + NB - k) % NB;
      col_s[k] = rd_data_s[BW'(bi)];
    end
  end

  // Mask rows that do not exist yet in this frame and fill them per the border mode.
  always_comb begin
    nxt_p_s    = {(PW*NUM_LINES){1'b0}};
    nxt_rows_s = {NUM_LINES{1'b0}};
    for (int k = 0; k < NUM_LINES; k++) begin
      if (k <= int'(lc_d1_r)) begin
        nxt_p_s[k*PW +: PW] = col_s[k];
        nxt_rows_s[k]       = valid_d1_r;
      end else if (BORDER_MODE == 1) begin
        nxt_p_s[k*PW +: PW] = col_s[lc_d1_r];
        nxt_rows_s[k]       = 1'b0;
      end else begin
        nxt_p_s[k*PW +: PW] = {PW{1'b0}};
        nxt_rows_s[k]       = 1'b0;
      end
    end
  end

  // Stage 2: registered outputs; the column reads as zero while no word is presented.
  always_ff @(posedge i_pclk or negedge i_arstn) begin
    if (!i_arstn) begin
      o_vsync      <= 1'b0;
      o_valid      <= 1'b0;
      o_p          <= {(PW*NUM_LINES){1'b0}};
      o_rows_valid <= {NUM_LINES{1'b0}};
      o_line_end   <= 1'b0;
    end else begin
      o_vsync <= vs_d1_r;
      o_valid <= valid_d1_r;
      if (valid_d1_r) begin
        o_p          <= nxt_p_s;
        o_rows_valid <= nxt_rows_s;
        o_line_end   <= end_d1_r;
      end else begin
        o_p          <= {(PW*NUM_LINES){1'b0}};
        o_rows_valid <= {NUM_LINES{1'b0}};
        o_line_end   <= 1'b0;
      end
    end
  end

endmodule
